// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared encodings and request type for the cache request path
package cache_pkg;

    localparam int OFFSET_W   = 6;
    localparam int REQ_ADDR_W = 64;
    localparam int REQ_DATA_W = 64;

    typedef enum logic [1:0] {
        SZ_8  = 2'd0,
        SZ_16 = 2'd1,
        SZ_32 = 2'd2,
        SZ_64 = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        SET_IDLE = 2'b00,
        SET_RD   = 2'b01,
        SET_WR   = 2'b10
    } set_en_e;

    typedef struct packed {
        logic                  write;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
        size_e                 size;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    // Index of the last byte of an access; doubles as the alignment mask.
    function automatic logic [2:0] last_byte(input size_e size);
        case (size)
            SZ_8:    last_byte = 3'd0;
            SZ_16:   last_byte = 3'd1;
            SZ_32:   last_byte = 3'd3;
            default: last_byte = 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/req_fifo.sv
// rtl/req_fifo.sv - synchronous request FIFO with registered storage and no bypass
module req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cache_req_splitter.sv
// rtl/cache_req_splitter.sv - splits CPU requests into naturally aligned set beats; CACHE_REQ_STATS_EN adds counters
module cache_req_splitter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int OFFSET_W   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [1:0]           req_size,
`ifdef CACHE_REQ_STATS_EN
    input  logic                 stat_clr,
    output logic [31:0]          stat_reqs,
    output logic [31:0]          stat_splits,
`endif
    output logic [1:0]           set_en,
    input  logic                 set_ready,
    output logic [ADDR_W-OFFSET_W-1:0] block_n,
    output logic [OFFSET_W-1:0]  block_offset,
    output logic [DATA_W-1:0]    write_data,
    output logic [1:0]           data_size
);

    import cache_pkg::*;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BYTES = 2'd2
    } state_e;

    state_e            state;
    state_e            state_nxt;
    logic [2:0]        k;
    logic [2:0]        k_nxt;
    req_t              cur;
    req_t              head;
    req_t              in_req;
    logic [PTR_W:0]    count;
    logic              full;
    logic              empty;
    logic              push;
    logic              fifo_pop;
    logic              beat_done;
    logic              last_beat;
    logic              head_aligned;
    logic [ADDR_W-1:0] beat_addr;
    logic [63:0]       shifted;

    assign req_ready = (count < DEPTH_CNT);
    assign push      = req_valid && !full;

    always_comb begin
        in_req.write = req_write;
        in_req.addr  = REQ_ADDR_W'(req_addr);
        in_req.wdata = REQ_DATA_W'(req_wdata);
        in_req.size  = size_e'(req_size);
    end

    req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_req),
        .pop       (fifo_pop),
        .pop_data  (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign head_aligned = ((head.addr[2:0] & last_byte(head.size)) == 3'd0);
    assign beat_done    = (state != IDLE) && set_ready;
    assign last_beat    = (state == ISSUE) || (k == last_byte(cur.size));
    // Loading the next head in the same cycle the last beat retires keeps aligned traffic bubble-free.
    assign fifo_pop     = !empty && ((state == IDLE) || (beat_done && last_beat));

    assign beat_addr = (state == BYTES) ? (cur.addr[ADDR_W-1:0] + ADDR_W'(k))
                                        : cur.addr[ADDR_W-1:0];
    assign shifted   = cur.wdata >> {k, 3'b000};

    always_comb begin
        state_nxt    = state;
        k_nxt        = k;
        set_en       = SET_IDLE;
        block_n      = '0;
        block_offset = '0;
        write_data   = '0;
        data_size    = SZ_8;

        if (fifo_pop) begin
            state_nxt = head_aligned ? ISSUE : BYTES;
            k_nxt     = 3'd0;
        end else if (beat_done && last_beat) begin
            state_nxt = IDLE;
            k_nxt     = 3'd0;
        end else if (beat_done) begin
            k_nxt = k + 3'd1;
        end

        case (state)
            ISSUE: begin
                set_en       = cur.write ? SET_WR : SET_RD;
                block_n      = beat_addr[ADDR_W-1:OFFSET_W];
                block_offset = beat_addr[OFFSET_W-1:0];
                write_data   = cur.write ? cur.wdata[DATA_W-1:0] : '0;
                data_size    = cur.size;
            end
            BYTES: begin
                set_en       = cur.write ? SET_WR : SET_RD;
                block_n      = beat_addr[ADDR_W-1:OFFSET_W];
                block_offset = beat_addr[OFFSET_W-1:0];
                write_data   = cur.write ? {{(DATA_W-8){1'b0}}, shifted[7:0]} : '0;
                data_size    = SZ_8;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= 3'd0;
            cur   <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            if (fifo_pop) begin
                cur <= head;
            end
        end
    end

`ifdef CACHE_REQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_reqs   <= '0;
            stat_splits <= '0;
        end else if (stat_clr) begin
            stat_reqs   <= '0;
            stat_splits <= '0;
        end else begin
            if (push && (stat_reqs != '1)) begin
                stat_reqs <= stat_reqs + 32'd1;
            end
            if (fifo_pop && !head_aligned && (stat_splits != '1)) begin
                stat_splits <= stat_splits + 32'd1;
            end
        end
    end
`endif

endmodule
